// File: rtl/regfile.sv
// regfile: four-entry general-purpose register file with two combinational
// read ports, one synchronous write port and a dedicated stack-pointer output.
// R3 doubles as the stack pointer and is reset to SP_RESET; R0..R2 reset to 0.
// Optional feature macro: REGFILE_BYPASS_EN enables write-first forwarding
// from the write port to each read port within the same cycle.
module regfile #(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  SP_RESET = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rd_addr1,
  input  logic [1:0]        rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] sp_out
);

  localparam int NUM_REGS = 4;
  localparam logic [1:0] SP_IDX = 2'd3;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // A write that will actually land on the next edge; reset discards it.
  logic wr_live;
  assign wr_live = wr_en && !rst;

  // Register storage: reset wins over a simultaneous write, otherwise the
  // addressed register loads the write data and the rest hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs[0] <= '0;
      regs[1] <= '0;
      regs[2] <= '0;
      regs[3] <= SP_RESET;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read port 1: stored value, replaced by the in-flight write data when the
  // same register is being written this cycle.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (wr_live && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
    end
  end

  // Read port 2: same forwarding rule, independent of port 1.
  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (wr_live && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
    end
  end
`else
  // Read port 1: plain stored value; a write shows up only after its edge.
  always_comb begin
    rd_data1 = regs[rd_addr1];
  end

  // Read port 2: plain stored value, independent of port 1.
  always_comb begin
    rd_data2 = regs[rd_addr2];
  end

  // Without forwarding the live-write qualifier has no reader.
  logic unused_wr_live;
  assign unused_wr_live = wr_live;
`endif

  // The stack pointer always reflects stored R3 and is never forwarded.
  assign sp_out = regs[SP_IDX];

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile. Expected values are
// hand-computed; forwarding-dependent expectations follow REGFILE_BYPASS_EN.
module tb_regfile;

  localparam int DATA_W = 8;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [1:0]        rd_addr1;
  logic [1:0]        rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] sp_out;

  int n_compared;
  int n_mismatched;

  regfile #(.DATA_W(DATA_W), .SP_RESET(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sp_out   (sp_out)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge, where inputs are driven and
  // outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    rd_addr1 = 2'd0;
    rd_addr2 = 2'd1;
    #1;
    n_compared++;
    if (sp_out !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL reset_sp: got %h expected %h", sp_out, 8'hFF);
    end
    n_compared++;
    if (rd_data1 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_r0: got %h expected %h", rd_data1, 8'h00);
    end
    n_compared++;
    if (rd_data2 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_r1: got %h expected %h", rd_data2, 8'h00);
    end
    rd_addr1 = 2'd2;
    rd_addr2 = 2'd3;
    #1;
    n_compared++;
    if (rd_data1 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_r2: got %h expected %h", rd_data1, 8'h00);
    end
    n_compared++;
    if (rd_data2 !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL reset_r3_read: got %h expected %h", rd_data2, 8'hFF);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] exp_pre;
    rd_addr1 = 2'd1;
    rd_addr2 = 2'd0;
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 8'h55;
    #1;
    exp_pre = BYPASS ? 8'h55 : 8'h00;
    n_compared++;
    if (rd_data1 !== exp_pre) begin
      n_mismatched++;
      $display("[TB] FAIL single_write_pre: got %h expected %h", rd_data1, exp_pre);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_compared++;
    if (rd_data1 !== 8'h55) begin
      n_mismatched++;
      $display("[TB] FAIL single_write_r1: got %h expected %h", rd_data1, 8'h55);
    end
    n_compared++;
    if (rd_data2 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL single_write_r0_held: got %h expected %h", rd_data2, 8'h00);
    end
  endtask

  task automatic test_dual_read();
    wr_en = 1'b1;
    wr_addr = 2'd2;
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    rd_addr1 = 2'd1;
    rd_addr2 = 2'd2;
    #1;
    n_compared++;
    if (rd_data1 !== 8'h55) begin
      n_mismatched++;
      $display("[TB] FAIL dual_read_p1: got %h expected %h", rd_data1, 8'h55);
    end
    n_compared++;
    if (rd_data2 !== 8'hAA) begin
      n_mismatched++;
      $display("[TB] FAIL dual_read_p2: got %h expected %h", rd_data2, 8'hAA);
    end
    rd_addr1 = 2'd2;
    #1;
    n_compared++;
    if (rd_data1 !== 8'hAA) begin
      n_mismatched++;
      $display("[TB] FAIL dual_read_same_reg: got %h expected %h", rd_data1, 8'hAA);
    end
  endtask

  task automatic test_write_first();
    logic [7:0] exp_pre;
    wr_en = 1'b1;
    wr_addr = 2'd0;
    wr_data = 8'h77;
    rd_addr1 = 2'd0;
    rd_addr2 = 2'd0;
    #1;
    exp_pre = BYPASS ? 8'h77 : 8'h00;
    n_compared++;
    if (rd_data1 !== exp_pre) begin
      n_mismatched++;
      $display("[TB] FAIL write_first_p1: got %h expected %h", rd_data1, exp_pre);
    end
    n_compared++;
    if (rd_data2 !== exp_pre) begin
      n_mismatched++;
      $display("[TB] FAIL write_first_p2: got %h expected %h", rd_data2, exp_pre);
    end
    rd_addr2 = 2'd2;
    #1;
    n_compared++;
    if (rd_data2 !== 8'hAA) begin
      n_mismatched++;
      $display("[TB] FAIL write_first_other_port: got %h expected %h", rd_data2, 8'hAA);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_compared++;
    if (rd_data1 !== 8'h77) begin
      n_mismatched++;
      $display("[TB] FAIL write_first_post: got %h expected %h", rd_data1, 8'h77);
    end
  endtask

  task automatic test_sp_update();
    logic [7:0] exp_pre;
    wr_en = 1'b1;
    wr_addr = 2'd3;
    wr_data = 8'hF0;
    rd_addr2 = 2'd3;
    #1;
    n_compared++;
    if (sp_out !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL sp_pre_edge: got %h expected %h", sp_out, 8'hFF);
    end
    exp_pre = BYPASS ? 8'hF0 : 8'hFF;
    n_compared++;
    if (rd_data2 !== exp_pre) begin
      n_mismatched++;
      $display("[TB] FAIL sp_read_pre_edge: got %h expected %h", rd_data2, exp_pre);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_compared++;
    if (sp_out !== 8'hF0) begin
      n_mismatched++;
      $display("[TB] FAIL sp_post_edge: got %h expected %h", sp_out, 8'hF0);
    end
    n_compared++;
    if (rd_data2 !== 8'hF0) begin
      n_mismatched++;
      $display("[TB] FAIL sp_read_post_edge: got %h expected %h", rd_data2, 8'hF0);
    end
  endtask

  task automatic test_back_to_back();
    rd_addr1 = 2'd1;
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_en = 1'b0;
    wr_data = 8'h99;
    #1;
    n_compared++;
    if (rd_data1 !== 8'h22) begin
      n_mismatched++;
      $display("[TB] FAIL back_to_back_last_wins: got %h expected %h", rd_data1, 8'h22);
    end
    tick();
    n_compared++;
    if (rd_data1 !== 8'h22) begin
      n_mismatched++;
      $display("[TB] FAIL write_disabled_hold: got %h expected %h", rd_data1, 8'h22);
    end
  endtask

  task automatic test_reset_vs_write();
    rst = 1'b1;
    wr_en = 1'b1;
    wr_addr = 2'd3;
    wr_data = 8'h12;
    rd_addr1 = 2'd3;
    rd_addr2 = 2'd0;
    #1;
    n_compared++;
    if (rd_data1 !== 8'hF0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_blocks_bypass: got %h expected %h", rd_data1, 8'hF0);
    end
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    #1;
    n_compared++;
    if (sp_out !== 8'hFF) begin
      n_mismatched++;
      $display("[TB] FAIL reset_vs_write_sp: got %h expected %h", sp_out, 8'hFF);
    end
    n_compared++;
    if (rd_data2 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_vs_write_r0: got %h expected %h", rd_data2, 8'h00);
    end
    rd_addr1 = 2'd1;
    rd_addr2 = 2'd2;
    #1;
    n_compared++;
    if (rd_data1 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_vs_write_r1: got %h expected %h", rd_data1, 8'h00);
    end
    n_compared++;
    if (rd_data2 !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL reset_vs_write_r2: got %h expected %h", rd_data2, 8'h00);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_compared = 0;
    n_mismatched = 0;
    rst = 1'b1;
    rd_addr1 = 2'd0;
    rd_addr2 = 2'd0;
    wr_en = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'h00;
    $display("[TB] regfile bench start, bypass=%0d", BYPASS);
    test_reset();
    test_single_write();
    test_dual_read();
    test_write_first();
    test_sp_update();
    test_back_to_back();
    test_reset_vs_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
